// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared seven-segment glyphs, widths and scan-capture state encoding
package ssd_pkg;

  localparam int SEG_W = 7;

  // Active-low abcdefg, bit 6 = a, bit 0 = g
  localparam logic [SEG_W-1:0] GLYPH_0 = 7'b0000001;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'b1001111;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'b0010010;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'b0000110;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'b1001100;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'b0100100;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'b0100000;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'b0001111;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'b0000100;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'b0001000;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'b1100000;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'b0110001;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'b1000010;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'b0110000;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'b0111000;

  typedef enum logic [1:0] {
    S_BLANK  = 2'd0,
    S_SETTLE = 2'd1,
    S_HELD   = 2'd2
  } state_t;

endpackage

// File: rtl/ssd_encode.sv
// rtl/ssd_encode.sv - inverse glyph table: segment pattern to hex nibble
module ssd_encode
  import ssd_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic [3:0]       nibble,
  output logic             known
);

  always_comb begin
    nibble = 4'h0;
    known  = 1'b1;
    case (seg)
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: known  = 1'b0;
    endcase
  end

endmodule

// File: rtl/ssd_scan_capture.sv
// rtl/ssd_scan_capture.sv - samples a multiplexed active-low seven-segment bus and rebuilds the hex word
module ssd_scan_capture
  import ssd_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEG_W-1:0]      seg_i,
  input  logic [DIGITS-1:0]     an_i,
  output logic [4*DIGITS-1:0]   value_o,
  output logic                  valid_o,
  output logic                  digit_err_o,
  output logic                  frame_err_o,
  output logic                  timeout_o
);

  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int LW = $clog2(DIGITS + 1);

  logic [SEG_W-1:0]    seg_q, seg_p;
  logic [DIGITS-1:0]   an_q, an_p;
  state_t              state;
  logic [CW-1:0]       cnt;
  logic [DIGITS-1:0]   mask;
  logic [4*DIGITS-1:0] buffer;
  logic [TW-1:0]       tcnt;

  logic [3:0]          nibble;
  logic                known;
  logic                blank, same, accept, multi;
  logic [LW-1:0]       lows;
  logic [IW-1:0]       idx;

  ssd_encode u_encode (
    .seg    (seg_q),
    .nibble (nibble),
    .known  (known)
  );

  always_comb begin
    lows = '0;
    idx  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_q[i]) begin
        lows = lows + 1'b1;
        idx  = IW'(i);
      end
    end
  end

  assign blank = &an_q;
  assign same  = (an_q == an_p) && (seg_q == seg_p);
  assign multi = lows > LW'(1);
  // The sample arriving on this edge is the STABLE_CYCLES-th identical one
  assign accept = (state == S_SETTLE) && !blank && same && (cnt == CW'(STABLE_CYCLES - 2));

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q       <= '1;
      seg_p       <= '1;
      an_q        <= '1;
      an_p        <= '1;
      state       <= S_BLANK;
      cnt         <= '0;
      mask        <= '0;
      buffer      <= '0;
      tcnt        <= '0;
      value_o     <= '0;
      valid_o     <= 1'b0;
      digit_err_o <= 1'b0;
      frame_err_o <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      seg_q       <= seg_i;
      an_q        <= an_i;
      seg_p       <= seg_q;
      an_p        <= an_q;
      valid_o     <= 1'b0;
      digit_err_o <= 1'b0;
      frame_err_o <= 1'b0;
      timeout_o   <= 1'b0;

      case (state)
        S_BLANK: begin
          cnt <= '0;
          if (!blank) state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (blank) begin
            state <= S_BLANK;
            cnt   <= '0;
          end else if (!same) begin
            cnt <= '0;
          end else if (accept) begin
            state <= S_HELD;
            cnt   <= cnt + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HELD: begin
          if (blank) begin
            state <= S_BLANK;
            cnt   <= '0;
          end else if (!same) begin
            state <= S_SETTLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= S_BLANK;
          cnt   <= '0;
        end
      endcase

      if (&mask) begin
        value_o <= buffer;
        valid_o <= 1'b1;
        mask    <= '0;
      end

      // An acceptance always beats a coincident timeout
      if (accept) begin
        tcnt <= '0;
        if (multi) begin
          frame_err_o <= 1'b1;
          mask        <= '0;
          buffer      <= '0;
        end else if (!known) begin
          digit_err_o <= 1'b1;
          mask        <= '0;
        end else begin
          buffer[4*idx +: 4] <= nibble;
          mask[idx]          <= 1'b1;
        end
      end else if ((&mask) || !(|mask)) begin
        tcnt <= '0;
      end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        tcnt      <= '0;
        mask      <= '0;
        timeout_o <= 1'b1;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_capture.sv
// tb/tb_ssd_scan_capture.sv - directed self-checking bench for ssd_scan_capture
module tb_ssd_scan_capture;

  localparam logic [6:0] G0 = 7'b0000001;
  localparam logic [6:0] G1 = 7'b1001111;
  localparam logic [6:0] G2 = 7'b0010010;
  localparam logic [6:0] G3 = 7'b0000110;
  localparam logic [6:0] G4 = 7'b1001100;
  localparam logic [6:0] G5 = 7'b0100100;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GF = 7'b0111000;
  localparam logic [6:0] GBAD = 7'b1111110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_i = 7'h7F;
  logic [3:0]  an_i = 4'hF;
  logic [15:0] value_o;
  logic        valid_o, digit_err_o, frame_err_o, timeout_o;

  int n_checks = 0;
  int n_fails  = 0;
  int n_valid = 0, n_derr = 0, n_ferr = 0, n_tout = 0;
  int b_valid = 0, b_derr = 0, b_ferr = 0, b_tout = 0;
  int k;

  ssd_scan_capture #(
    .DIGITS         (4),
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_i       (seg_i),
    .an_i        (an_i),
    .value_o     (value_o),
    .valid_o     (valid_o),
    .digit_err_o (digit_err_o),
    .frame_err_o (frame_err_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid_o)     n_valid++;
    if (digit_err_o) n_derr++;
    if (frame_err_o) n_ferr++;
    if (timeout_o)   n_tout++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_valid = n_valid;
    b_derr  = n_derr;
    b_ferr  = n_ferr;
    b_tout  = n_tout;
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] pat, input int n);
    an_i  = an;
    seg_i = pat;
    repeat (n) @(negedge clk);
    an_i  = 4'hF;
    seg_i = 7'h7F;
    repeat (2) @(negedge clk);
  endtask

  task automatic show(input int d, input logic [6:0] pat, input int n);
    logic [3:0] one;
    one = 4'b0001;
    drive(~(one << d), pat, n);
  endtask

  task automatic scan(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2, input logic [6:0] p3);
    show(0, p0, 6);
    show(1, p1, 6);
    show(2, p2, 6);
    show(3, p3, 6);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_value", 32'(value_o), 32'h0);
    check("rst_pulses", {28'h0, valid_o, digit_err_o, frame_err_o, timeout_o}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: clean frame
    snap();
    scan(G5, GA, G0, GF);
    check("t1_valid", n_valid - b_valid, 1);
    check("t1_value", 32'(value_o), 32'hF0A5);
    check("t1_errs", (n_derr - b_derr) + (n_ferr - b_ferr), 0);

    // 2: digit1 too short, then rescanned long enough
    snap();
    show(0, G5, 6);
    show(1, GA, 3);
    show(2, G0, 6);
    show(3, GF, 6);
    repeat (4) @(negedge clk);
    check("t2_short_novalid", n_valid - b_valid, 0);
    show(1, GA, 6);
    repeat (4) @(negedge clk);
    check("t2_valid", n_valid - b_valid, 1);
    check("t2_value", 32'(value_o), 32'hF0A5);

    // 3: unknown glyph poisons the frame
    snap();
    show(0, G1, 6);
    show(1, G2, 6);
    show(2, GBAD, 6);
    check("t3_digit_err", n_derr - b_derr, 1);
    show(2, G3, 6);
    show(3, G4, 6);
    repeat (4) @(negedge clk);
    check("t3_poisoned_novalid", n_valid - b_valid, 0);
    scan(G1, G2, G3, G4);
    check("t3_valid", n_valid - b_valid, 1);
    check("t3_value", 32'(value_o), 32'h4321);
    check("t3_no_frame_err", n_ferr - b_ferr, 0);

    // 4: two anodes low
    snap();
    drive(4'b1100, G8, 6);
    repeat (2) @(negedge clk);
    check("t4_frame_err", n_ferr - b_ferr, 1);
    check("t4_no_digit_err", n_derr - b_derr, 0);
    check("t4_novalid", n_valid - b_valid, 0);

    // 5: partial frame times out 50 cycles after the last acceptance
    snap();
    show(0, G8, 6);
    an_i  = 4'b1101;
    seg_i = G8;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 6) begin
        an_i  = 4'hF;
        seg_i = 7'h7F;
      end
    end while (!timeout_o && k < 200);
    check("t5_timeout_cycle", k, 55);
    repeat (60) @(negedge clk);
    check("t5_timeout_once", n_tout - b_tout, 1);
    check("t5_novalid", n_valid - b_valid, 0);
    scan(G8, G8, G8, G8);
    check("t5_valid", n_valid - b_valid, 1);
    check("t5_value", 32'(value_o), 32'h8888);

    // 6: reset mid-frame
    snap();
    show(0, G1, 6);
    show(1, G2, 6);
    show(2, G3, 6);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_value", 32'(value_o), 32'h0);
    check("t6_rst_pulses", {28'h0, valid_o, digit_err_o, frame_err_o, timeout_o}, 32'h0);
    rst = 1'b0;
    show(3, G4, 6);
    repeat (4) @(negedge clk);
    check("t6_novalid", n_valid - b_valid, 0);
    check("t6_no_errs", (n_derr - b_derr) + (n_ferr - b_ferr) + (n_tout - b_tout), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
